// File: rtl/ir_pkg.sv
// Shared widths, field offsets and entry layout for the IR key queue.
// Frames are {~key, key, custom}; queued entries are {repeat, key, custom}.
package ir_pkg;

    localparam int IR_FRAME_W  = 32;
    localparam int IR_ENTRY_W  = 25;
    localparam int IR_CUST_LSB = 0;
    localparam int IR_CUST_W   = 16;
    localparam int IR_KEY_LSB  = 16;
    localparam int IR_KEY_W    = 8;
    localparam int IR_NKEY_LSB = 24;

    typedef struct packed {
        logic                 rpt;
        logic [IR_KEY_W-1:0]  key;
        logic [IR_CUST_W-1:0] custom;
    } ir_entry_t;

    function automatic logic ir_frame_ok(input logic [IR_FRAME_W-1:0] f);
        logic [IR_KEY_W-1:0] w_nkey;
        w_nkey = ~f[IR_KEY_LSB +: IR_KEY_W];
        return f[IR_NKEY_LSB +: IR_KEY_W] == w_nkey;
    endfunction

endpackage

// File: rtl/ir_key_queue_if.sv
// Host-side bundle of the IR key queue: frame input, queue control and status.
// master drives frames/pop/clr, slave is the queue itself.
interface ir_key_queue_if #(
    parameter int DEPTH = 8
);
    logic                     frame_valid;
    logic [31:0]              frame_data;
    logic [15:0]              addr_match;
    logic                     pop;
    logic                     clr;
    logic                     empty;
    logic [24:0]              head;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic [7:0]               err_count;
    logic                     irq;

    modport master (
        output frame_valid, frame_data, addr_match, pop, clr,
        input  empty, head, level, overflow, err_count, irq
    );

    modport slave (
        input  frame_valid, frame_data, addr_match, pop, clr,
        output empty, head, level, overflow, err_count, irq
    );
endinterface

// File: rtl/ir_key_fifo.sv
// Synchronous first-word-fall-through FIFO of decoded key entries.
// A push while full is only taken when a pop frees a slot on the same edge.
module ir_key_fifo
    import ir_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  ir_entry_t              i_data,
    input  logic                   i_pop,
    output logic                   o_full,
    output logic                   o_empty,
    output ir_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    ir_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = r_level == (AW+1)'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_head  = o_empty ? '0 : r_mem[r_rd];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || i_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/ir_key_queue.sv
// NEC key queue: two-stage frame pipeline, complement/address checks,
// repeat detection within a holdoff window, and FWFT key storage.
module ir_key_queue
    import ir_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int HOLDOFF        = 5400000,
    parameter int ADDR_FILTER_EN = 0
) (
    input  logic           clk,
    input  logic           reset,
    ir_key_queue_if.slave  bus
);
    localparam int HW = $clog2(HOLDOFF + 1);

    logic                   r_s1_vld;
    logic [IR_FRAME_W-1:0]  r_s1_data;
    logic                   r_s2_vld;
    logic [IR_FRAME_W-1:0]  r_s2_data;
    logic [HW-1:0]          r_hold;
    logic [23:0]            r_last;
    logic                   r_ovf;
    logic [7:0]             r_err;

    logic                   w_addr_ok;
    logic                   w_err;
    logic                   w_req;
    logic                   w_ovf;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    ir_entry_t              w_entry;
    ir_entry_t              w_head;
    logic [$clog2(DEPTH):0] w_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_data <= '0;
        end else begin
            r_s1_vld <= bus.frame_valid;
            r_s2_vld <= r_s1_vld;
            if (bus.frame_valid) r_s1_data <= bus.frame_data;
            if (r_s1_vld)        r_s2_data <= r_s1_data;
        end
    end

    // Address filtering takes precedence: filtered frames never count as errors.
    always_comb begin
        w_addr_ok      = (ADDR_FILTER_EN == 0) ||
                         (r_s2_data[IR_CUST_LSB +: IR_CUST_W] == bus.addr_match);
        w_err          = r_s2_vld && w_addr_ok && !ir_frame_ok(r_s2_data);
        w_req          = r_s2_vld && w_addr_ok && ir_frame_ok(r_s2_data);
        w_ovf          = w_req && w_full && !bus.pop;
        w_push         = w_req && !w_ovf;
        w_entry.key    = r_s2_data[IR_KEY_LSB +: IR_KEY_W];
        w_entry.custom = r_s2_data[IR_CUST_LSB +: IR_CUST_W];
        w_entry.rpt    = (r_hold != '0) &&
                         ({w_entry.key, w_entry.custom} == r_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
            r_last <= '0;
        end else if (w_push) begin
            r_hold <= HW'(HOLDOFF);
            r_last <= {w_entry.key, w_entry.custom};
        end else if (r_hold != '0) begin
            r_hold <= r_hold - HW'(1);
        end
    end

    // An error/overflow on the same edge as clr leaves the fresh event visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_err)        r_err <= bus.clr ? 8'd1 :
                                       (r_err == 8'hFF) ? r_err : r_err + 8'd1;
            else if (bus.clr) r_err <= '0;
            if (w_ovf)        r_ovf <= 1'b1;
            else if (bus.clr) r_ovf <= 1'b0;
        end
    end

    ir_key_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (bus.pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_level (w_level)
    );

    assign bus.empty     = w_empty;
    assign bus.irq       = ~w_empty;
    assign bus.head      = w_head;
    assign bus.level     = w_level;
    assign bus.overflow  = r_ovf;
    assign bus.err_count = r_err;
endmodule
